// File: rtl/rca_serial_ctrl.sv
// Nibble-serial add/sub sequencer driving one shared external 4-bit ripple-carry adder.
// Optional status flags (flag_z, flag_n, flag_v) are built when RCA_SERIAL_FLAGS_EN is defined.
module rca_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [3:0]       rca_a,
  output logic [3:0]       rca_b,
  output logic             rca_ci,
  input  logic [3:0]       rca_s,
  input  logic             rca_co
`ifdef RCA_SERIAL_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic [IW-1:0]    r_index;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;
  logic [IW+1:0]    w_base;

  assign w_base = {r_index, 2'b00};
  assign w_last = (r_state == RUN) && (r_index == IW'(NIB - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_accept    = start;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Adder is fed only during RUN; the first pass injects the subtract carry-in.
  always_comb begin
    rca_a  = 4'h0;
    rca_b  = 4'h0;
    rca_ci = 1'b0;
    if (r_state == RUN) begin
      rca_a  = r_a[w_base +: 4];
      rca_b  = r_b[w_base +: 4] ^ {4{r_sub}};
      rca_ci = (r_index == '0) ? r_sub : r_carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_index  <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sub   <= op_sub;
        r_index <= '0;
      end
      if (r_state == RUN) begin
        r_result[w_base +: 4] <= rca_s;
        r_carry               <= rca_co;
        r_index               <= r_index + IW'(1);
        if (w_last) r_cout <= rca_co;
      end
    end
  end

`ifdef RCA_SERIAL_FLAGS_EN
  // Flags are captured alongside the final nibble, so the zero test merges the incoming sum nibble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (w_last) begin
      flag_z <= ({rca_s, r_result[WIDTH-5:0]} == '0);
      flag_n <= rca_s[3];
      flag_v <= r_carry ^ rca_co;
    end
  end
`endif

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Scoreboard bench for rca_serial_ctrl (WIDTH=32) with a behavioural 4-bit adder alongside.
// Flag checks are compiled in when RCA_SERIAL_FLAGS_EN is defined.
module tb_rca_serial_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic [3:0]  rca_a;
  logic [3:0]  rca_b;
  logic        rca_ci;
  logic [3:0]  rca_s;
  logic        rca_co;
`ifdef RCA_SERIAL_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
`endif

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        z;
    logic        n;
    logic        v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rca_serial_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .rca_a(rca_a), .rca_b(rca_b), .rca_ci(rca_ci), .rca_s(rca_s), .rca_co(rca_co)
`ifdef RCA_SERIAL_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
`endif
  );

  // External combinational ripple-carry adder.
  assign {rca_co, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'h0, rca_ci};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("result", result, e.res);
        check("cout", cout, e.co);
`ifdef RCA_SERIAL_FLAGS_EN
        check("flag_z", flag_z, e.z);
        check("flag_n", flag_n, e.n);
        check("flag_v", flag_v, e.v);
`endif
      end
    end
  end

  // Drives start in the current cycle (caller is at a negedge), returns at the pass-0 negedge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input bit expect_done, input logic [31:0] eres,
                       input logic eco, input logic ez, input logic en, input logic ev);
    a      = ia;
    b      = ib;
    op_sub = isub;
    start  = 1'b1;
    if (expect_done) q.push_back('{eres, eco, ez, en, ev, cyc + 9});
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op_sub  = 1'b0;
    a       = 32'h0;
    b       = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_rca", {rca_a, rca_b, rca_ci}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1 from IDLE, with pass-0/pass-1 adder drive checks
    issue(32'h0000000F, 32'h00000001, 1'b0, 1, 32'h00000010, 0, 0, 0, 0);
    check("t1_busy", busy, 1);
    check("t1_p0_drive", {rca_a, rca_b, rca_ci}, {4'hF, 4'h1, 1'b0});
    @(negedge clk);
    check("t1_p1_drive", {rca_a, rca_b, rca_ci}, {4'h0, 4'h0, 1'b1});
    wait_done();

    // T2 wrap, started straight from DONE
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 32'h00000000, 1, 1, 0, 0);
    wait_done();

    // T3 subtraction both directions
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rca", {rca_a, rca_b, rca_ci}, 0);
    issue(32'd5, 32'd7, 1'b1, 1, 32'hFFFFFFFE, 0, 0, 1, 0);
    check("t3_p0_drive", {rca_a, rca_b, rca_ci}, {4'h5, 4'h8, 1'b1});
    wait_done();
    @(negedge clk);
    issue(32'd7, 32'd5, 1'b1, 1, 32'h00000002, 1, 0, 0, 0);
    wait_done();

    // T4 signed overflow
    @(negedge clk);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1, 32'h80000000, 0, 0, 1, 1);
    wait_done();

    // T5 start while busy is ignored; then start held in DONE chains the next op
    @(negedge clk);
    issue(32'h12345678, 32'h11111111, 1'b0, 1, 32'h23456789, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    a      = 32'hDEADBEEF;
    b      = 32'h01010101;
    start  = 1'b1;
    check("t5_busy_ignore", busy, 1);
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    issue(32'h80000000, 32'h80000000, 1'b0, 1, 32'h00000000, 1, 1, 0, 1);
    wait_done();
    @(negedge clk);
    issue(32'd3, 32'd4, 1'b0, 1, 32'h00000007, 0, 0, 0, 0);
    wait_done();

    // T6 reset during pass 3 discards the op
    @(negedge clk);
    issue(32'h11111111, 32'h11111111, 1'b0, 0, 32'h0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_result", result, 0);
    check("t6_cout", cout, 0);
`ifdef RCA_SERIAL_FLAGS_EN
    check("t6_flags", {flag_z, flag_n, flag_v}, 0);
`endif
    reset_n = 1'b1;
    repeat (15) @(negedge clk);

    // Recovery: 0xF - 0xF
    issue(32'h0000000F, 32'h0000000F, 1'b1, 1, 32'h00000000, 1, 1, 0, 0);
    wait_done();
    repeat (3) @(negedge clk);
    check("pending_expect", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
